multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore FSM that sequences the multi-cycle MIPS datapath (PC, memory, IR, register file, ALU) one instruction at a time.
- Drives every datapath mux and write enable, plus the 2-bit alu_op consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct.
- Sits beside the datapath top and takes only the IR opcode field as input.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width (exported on the state port).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPW  IR[31:26], valid from the DECODE cycle onward.
- zero  in  1  ALU zero flag.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero (branch).
- pc_en  out  1  pc_write OR (pc_write_cond AND zero).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B input: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  out  2  operation class sent to ALU control.
- pc_source  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state  out  STW  current state, for debug.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. While rst is high, the state register loads FETCH at the next edge and every output is forced to 0, including state.
- Opcodes decoded: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000.
- Outputs are purely a function of the current state (Moore), except pc_en, which also uses zero. Any output not listed for a state is 0.
- FETCH (0): mem_read, ir_write, alu_src_b = 01, alu_op = 00, pc_write. Next: DECODE.
- DECODE (1): alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - LW, SW, ADDI -> MEM_ADDR
  - R -> R_EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - any other -> FETCH, with illegal_op = 1 for this cycle.
- MEM_ADDR (2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: LW -> MEM_READ; SW -> MEM_WRITE; ADDI -> ADDI_WB.
- MEM_READ (3): mem_read, i_or_d = 1. Next: MEM_WB.
- MEM_WB (4): reg_write, mem_to_reg = 1, reg_dst = 0. Next: FETCH.
- MEM_WRITE (5): mem_write, i_or_d = 1. Next: FETCH.
- R_EXEC (6): alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next: R_WB.
- R_WB (7): reg_write, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
- BRANCH (8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond, pc_source = 01. Next: FETCH.
- JUMP (9): pc_write, pc_source = 10. Next: FETCH.
- ADDI_WB (10): reg_write, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
- Latency in cycles: LW 5; SW, R, ADDI 4; BEQ, J 3.
- Unused state codes (11–15) -> FETCH on the next edge, all outputs 0.
- rst asserted mid-instruction aborts it; no write strobe is issued during the reset cycle.
- opcode is sampled only in DECODE and MEM_ADDR. Changes in other states are ignored.

Optional Feature:
- Macro: MC_MEM_WAIT_EN.
- With it defined: add input port mem_ready (1 bit). FETCH, MEM_READ and MEM_WRITE hold their state and their outputs until mem_ready = 1.
  - In FETCH, pc_write and ir_write assert only in the cycle where mem_ready = 1, so the PC increments exactly once per fetch.
  - rst still overrides the hold.
- Without it: no mem_ready port; every state lasts exactly one cycle.

Decomposition:
- Shared package mc_pkg holds:
  - opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - state encodings S_FETCH .. S_ADDI_WB
  - alu_op codes (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10)
  - alu_src_b and pc_source select codes.
- One natural sub-module: mc_output_decode, a combinational state -> control-word decoder. It lets the next-state logic and the output table be verified separately.

Test Plan:
- rst = 1 for 2 cycles, then release -> outputs all 0 during reset; cycle after release: state = 0, mem_read = ir_write = pc_write = 1, alu_src_b = 01.
- opcode = 100011 (LW) -> state sequence 0,1,2,3,4,0; reg_write = 1 and mem_to_reg = 1 only in state 4.
- opcode = 000000 (R) -> alu_op = 10 in state 6; reg_write = 1 and reg_dst = 1 in state 7; back to 0 after 4 cycles.
- opcode = 000100 (BEQ) with zero = 1 then zero = 0 -> pc_en = 1 with pc_source = 01 in the first case, pc_en = 0 in the second; alu_op = 01 both times.
- opcode = 111111 -> illegal_op pulses for exactly 1 cycle in state 1; next state 0; no reg_write or mem_write asserted.
- MC_MEM_WAIT_EN defined, mem_ready low for 3 cycles during SW -> state held at 5 with mem_write = 1 for 4 cycles, then FETCH; during FETCH stalls, pc_write pulses exactly once.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes,
// state encodings, select codes and the packed control word that the
// output decoder produces.
package mc_pkg;

    // Opcode field values of the supported instructions
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Controller states; codes 11..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_WB   = 4'd10
    } state_t;

    // Operation class handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B input select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath control driven purely by the current state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // True for the opcodes the controller knows how to sequence
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_R)  || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word table for the multi-cycle
// controller. Anything not set for a state stays 0.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Moore output table, one entry per state
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multi-cycle MIPS datapath one instruction
// at a time. Optional macro MC_MEM_WAIT_EN adds a mem_ready input that
// stretches FETCH, MEM_READ and MEM_WRITE until memory responds.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
`ifdef MC_MEM_WAIT_EN
    input  logic           mem_ready,
`endif
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           pc_en,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_source,
    output logic           illegal_op,
    output logic [STW-1:0] state
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl;
    logic       illegal;
    logic [5:0] op;

    assign op = opcode[5:0];

    // State register; reset restarts at FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEM_ADDR
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
`ifdef MC_MEM_WAIT_EN
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH  : S_MEM_WRITE;
`else
            S_FETCH:     state_d = S_DECODE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_MEM_WRITE: state_d = S_FETCH;
`endif
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW, OP_ADDI: state_d = S_MEM_ADDR;
                    OP_R:                  state_d = S_R_EXEC;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                case (op)
                    OP_LW:   state_d = S_MEM_READ;
                    OP_SW:   state_d = S_MEM_WRITE;
                    OP_ADDI: state_d = S_ADDI_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_R_EXEC: state_d = S_R_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl_raw)
    );

    // Output stage: fetch stall gating, illegal-opcode flag and reset blanking
    always_comb begin
        ctrl    = ctrl_raw;
        illegal = (state_q == S_DECODE) && !is_supported(op);
`ifdef MC_MEM_WAIT_EN
        if (state_q == S_FETCH && !mem_ready) begin
            ctrl.pc_write = 1'b0;
            ctrl.ir_write = 1'b0;
        end
`endif
        if (rst) begin
            ctrl    = '0;
            illegal = 1'b0;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = illegal;
    assign state         = rst ? '0 : STW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control. Each record is
// one clock cycle: inputs driven after the falling edge, outputs checked
// 1 ns later. Expected output words are packed as
// {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
//  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//  pc_source[1:0], illegal_op}.
module tb_multicycle_control;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] outs;
    } vec_t;

    localparam logic [17:0] E_ZERO   = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] E_FETCH  = 18'b1_0_1_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [17:0] E_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [17:0] E_DEC_IL = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [17:0] E_MADDR  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] E_MREAD  = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] E_MWB    = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [17:0] E_MWRITE = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] E_REXEC  = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [17:0] E_RWB    = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] E_BR_Z1  = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] E_BR_Z0  = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] E_JUMP   = 18'b1_0_1_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [17:0] E_ADDIWB = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [17:0] E_FSTALL = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [17:0] act;

    int vec_count   = 0;
    int miscompares = 0;
    int pulses      = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control #(.OPW(6), .STW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
`ifdef MC_MEM_WAIT_EN
        .mem_ready     (mem_ready),
`endif
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_en         (pc_en),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    assign act = {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, illegal_op};

    // Queue one cycle of the directed table
    task automatic addVec(input logic r, input logic [5:0] o, input logic z,
                          input logic [3:0] s, input logic [17:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.rdy = 1'b1; v.st = s; v.outs = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs just after the falling edge
    task automatic applyStimulus(input logic r, input logic [5:0] o,
                                 input logic z, input logic rd);
        @(negedge clk);
        rst       = r;
        opcode    = o;
        zero      = z;
        mem_ready = rd;
    endtask

    // Compare state and the packed output word against expectations
    task automatic checkOutput(input string name, input logic [3:0] exp_st,
                               input logic [17:0] exp_outs);
        #1;
        vec_count++;
        if (state !== exp_st || act !== exp_outs) begin
            miscompares++;
            $display("[TB] FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, act, exp_st, exp_outs);
        end
    endtask

    // Compare a bench-side counter against its required value
    task automatic checkCount(input string name, input int got, input int want);
        vec_count++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        // reset, then LW with opcode changed in MEM_READ/MEM_WB (must be ignored)
        addVec(1, 6'b100011, 0, 0, E_ZERO);
        addVec(1, 6'b100011, 0, 0, E_ZERO);
        addVec(0, 6'b100011, 0, 0, E_FETCH);
        addVec(0, 6'b100011, 0, 1, E_DEC);
        addVec(0, 6'b100011, 0, 2, E_MADDR);
        addVec(0, 6'b111111, 0, 3, E_MREAD);
        addVec(0, 6'b111111, 0, 4, E_MWB);
        // R-type
        addVec(0, 6'b000000, 0, 0, E_FETCH);
        addVec(0, 6'b000000, 0, 1, E_DEC);
        addVec(0, 6'b000000, 0, 6, E_REXEC);
        addVec(0, 6'b000000, 0, 7, E_RWB);
        // BEQ taken, then not taken
        addVec(0, 6'b000100, 1, 0, E_FETCH);
        addVec(0, 6'b000100, 1, 1, E_DEC);
        addVec(0, 6'b000100, 1, 8, E_BR_Z1);
        addVec(0, 6'b000100, 0, 0, E_FETCH);
        addVec(0, 6'b000100, 0, 1, E_DEC);
        addVec(0, 6'b000100, 0, 8, E_BR_Z0);
        // SW
        addVec(0, 6'b101011, 0, 0, E_FETCH);
        addVec(0, 6'b101011, 0, 1, E_DEC);
        addVec(0, 6'b101011, 0, 2, E_MADDR);
        addVec(0, 6'b101011, 0, 5, E_MWRITE);
        // ADDI
        addVec(0, 6'b001000, 0, 0, E_FETCH);
        addVec(0, 6'b001000, 0, 1, E_DEC);
        addVec(0, 6'b001000, 0, 2, E_MADDR);
        addVec(0, 6'b001000, 0, 10, E_ADDIWB);
        // J
        addVec(0, 6'b000010, 0, 0, E_FETCH);
        addVec(0, 6'b000010, 0, 1, E_DEC);
        addVec(0, 6'b000010, 0, 9, E_JUMP);
        // illegal opcode: one pulse in DECODE, then straight back to FETCH
        addVec(0, 6'b111111, 0, 0, E_FETCH);
        addVec(0, 6'b111111, 0, 1, E_DEC_IL);
        addVec(0, 6'b100011, 0, 0, E_FETCH);
        // LW aborted by reset in MEM_READ
        addVec(0, 6'b100011, 0, 1, E_DEC);
        addVec(0, 6'b100011, 0, 2, E_MADDR);
        addVec(1, 6'b100011, 0, 0, E_ZERO);
        addVec(0, 6'b100011, 0, 0, E_FETCH);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
        end

        // reset during MEM_WRITE: the reset cycle must not strobe mem_write
        applyStimulus(0, 6'b101011, 0, 1); checkOutput("sw_abort_dec", 1, E_DEC);
        applyStimulus(0, 6'b101011, 0, 1); checkOutput("sw_abort_addr", 2, E_MADDR);
        applyStimulus(0, 6'b101011, 0, 1); checkOutput("sw_abort_wr", 5, E_MWRITE);
        applyStimulus(1, 6'b101011, 0, 1); checkOutput("sw_abort_rst", 0, E_ZERO);
        applyStimulus(0, 6'b101011, 0, 1); checkOutput("sw_abort_fetch", 0, E_FETCH);

`ifdef MC_MEM_WAIT_EN
        // memory wait states: stalled FETCH then SW with 3 not-ready cycles
        applyStimulus(1, 6'b101011, 0, 0); checkOutput("wait_rst", 0, E_ZERO);
        pulses = 0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 6'b101011, 0, 0);
            checkOutput($sformatf("fetch_stall%0d", k), 0, E_FSTALL);
            if (pc_write) pulses++;
        end
        applyStimulus(0, 6'b101011, 0, 1); checkOutput("fetch_ready", 0, E_FETCH);
        if (pc_write) pulses++;
        checkCount("fetch_pc_write_pulses", pulses, 1);
        applyStimulus(0, 6'b101011, 0, 0); checkOutput("wait_dec", 1, E_DEC);
        applyStimulus(0, 6'b101011, 0, 0); checkOutput("wait_addr", 2, E_MADDR);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 6'b101011, 0, 0);
            checkOutput($sformatf("sw_hold%0d", k), 5, E_MWRITE);
        end
        applyStimulus(0, 6'b101011, 0, 1); checkOutput("sw_ready", 5, E_MWRITE);
        applyStimulus(0, 6'b101011, 0, 0); checkOutput("sw_done", 0, E_FSTALL);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
